z_core_muldiv_unit: RTL
=======================

Name: z_core_muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit downstream of the register file.
- Consumes the two source operands read from the register file and the decoded funct3/rd.
- Computes the result over multiple cycles and returns it as a one-cycle register-file write request (rd, rd_in, write_enable).
- The control unit stalls issue while the unit is busy.

Parameters:
XLEN, 32, operand/result width; only 32 supported.
CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
clk  input  1  rising-edge clock, single clock domain
reset  input  1  synchronous, active-high reset
start  input  1  issue request; accepted only when ready=1
flush  input  1  abort in-flight operation; no writeback
funct3  input  3  RV32M operation select
rd_in_idx  input  5  destination register index
rs1_val  input  32  operand A (rs1_out of register file)
rs2_val  input  32  operand B (rs2_out of register file)
ready  output  1  high in IDLE only
busy  output  1  high in CALC and DONE
result_valid  output  1  one-cycle pulse with result
wb_rd  output  5  destination index, valid with result_valid
wb_data  output  32  result, valid with result_valid
wb_we  output  1  = result_valid AND wb_rd!=0

Behaviour:
- Reset: state=IDLE, ready=1, busy=0, result_valid=0, wb_we=0, wb_rd=0, wb_data=0, counter=0. Reset overrides start and flush.
- funct3 encoding: 000 MUL (low 32 bits), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States and transitions:
  - IDLE: on start, latch operands, funct3 and rd. For signed operands, store absolute values and record the result sign (quotient sign = sA^sB; remainder sign = sA). Go to CALC with counter=0. Special cases go directly to DONE instead.
  - CALC: one bit per cycle. Multiply uses shift-add into a 64-bit accumulator; divide uses restoring shift-subtract producing a 32-bit quotient and remainder. After 32 iterations (counter reaches XLEN-1), go to DONE.
  - DONE: apply the sign correction, drive wb_data/wb_rd, assert result_valid for exactly one cycle, then return to IDLE.
- Latency: start accepted at edge E → result_valid is high in the cycle following edge E+33. Special cases: result_valid is high in the cycle following edge E+1.
- Special cases (decided in IDLE, no CALC):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1_val.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- start while busy is ignored; the operation is not queued.
- start in the same cycle DONE returns to IDLE is not accepted, because ready is low in DONE.
- flush in CALC or DONE: next state IDLE, result_valid/wb_we forced low that cycle and next. flush in IDLE with start: start is dropped.
- rd=0: result_valid still pulses; wb_we stays low.
- Outputs are registered; no combinational path from start to result_valid.

Optional Feature:
Z_CORE_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33×33 signed product computed in IDLE. Latency equals the special-case path (result in the cycle following E+1).
- Undefined: multiply uses the 32-cycle iterative path.
- Divide is iterative in both builds.

Decomposition:
- Shared package/include (z_core_defs): funct3 RV32M constants, state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2), XLEN.
- One natural sub-module: z_core_div_step, the combinational restoring-division step (remainder, divisor, quotient bit). Multiply step and control stay in the top module.

Test Plan:
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD) → wb_data=0xFFFFFFEB, 34 cycles after start (2 with Z_CORE_FAST_MUL_EN). MULHU: 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV: -20/3 → 0xFFFFFFFA (-6); REM: -20 rem 3 → 0xFFFFFFFE (-2); DIVU: 100/7 → 14; REMU → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5. Both with result_valid in the cycle after E+1. Overflow DIV 0x80000000/-1 → 0x80000000; REM → 0.
- Handshake: second start pulsed during CALC is ignored, with exactly one result_valid. rd=0 → result_valid=1, wb_we=0.
- flush at CALC cycle 10 → no result_valid/wb_we. ready returns high next cycle, and a new DIVU 9/2 completes with 4.
- reset asserted mid-CALC → all outputs zero and ready=1 next cycle. No write, even if reset is released exactly when DONE would have occurred.

Source files
------------

// File: rtl/z_core_muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: widths, funct3 codes,
// FSM encoding and the latched-operation control word.
package z_core_muldiv_unit_pkg;

  localparam int Z_XLEN  = 32;
  localparam int Z_CNT_W = 6;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // neg: final result needs two's-complement correction
  // byp: result already sits in the low accumulator half (special case / fast multiply)
  typedef struct packed {
    logic [2:0] f3;
    logic [4:0] rd;
    logic       neg;
    logic       byp;
  } ctl_t;

  function automatic logic [Z_XLEN-1:0] cond_neg(input logic [Z_XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

endpackage

// File: rtl/z_core_muldiv_unit_if.sv
// Issue/writeback bundle between the control unit (master) and the muldiv unit (slave).
interface z_core_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [4:0]      rd_in_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            ready;
  logic            busy;
  logic            result_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;

  modport master (
    output start, flush, funct3, rd_in_idx, rs1_val, rs2_val,
    input  ready, busy, result_valid, wb_rd, wb_data, wb_we
  );

  modport slave (
    input  start, flush, funct3, rd_in_idx, rs1_val, rs2_val,
    output ready, busy, result_valid, wb_rd, wb_data, wb_we
  );
endinterface

// File: rtl/z_core_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module z_core_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            din,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit
);
  logic [XLEN:0] shifted, diff;

  // rem_i < divisor keeps shifted below 2*divisor, so bit XLEN of diff is the borrow
  always_comb begin
    shifted = {rem_i, din};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[XLEN];
    rem_o   = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end
endmodule

// File: rtl/z_core_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a one-cycle writeback pulse.
// Z_CORE_FAST_MUL_EN: multiplies complete through a single-cycle product instead of shift-add.
module z_core_muldiv_unit
  import z_core_muldiv_unit_pkg::*;
#(
  parameter int XLEN  = Z_XLEN,
  parameter int CNT_W = Z_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  z_core_muldiv_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   op_q, op_d;
  ctl_t              ctl_q, ctl_d;
  logic              rv_q, rv_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  // issue-time decode
  logic            is_div, a_sgn, b_sgn, sa, sb, div0, ovf, neg;
  logic [XLEN-1:0] abs_a, abs_b, spec_res;

  always_comb begin
    is_div   = bus.funct3[2];
    a_sgn    = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_sgn    = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
    sa       = a_sgn & bus.rs1_val[XLEN-1];
    sb       = b_sgn & bus.rs2_val[XLEN-1];
    abs_a    = cond_neg(bus.rs1_val, sa);
    abs_b    = cond_neg(bus.rs2_val, sb);
    div0     = is_div && (bus.rs2_val == '0);
    ovf      = is_div && !bus.funct3[0] && (bus.rs2_val == '1) &&
               (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}});
    // remainder takes the dividend's sign, everything else the xor of both
    neg      = (is_div && bus.funct3[1]) ? sa : (sa ^ sb);
    if (div0) spec_res = bus.funct3[1] ? bus.rs1_val : '1;
    else      spec_res = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef Z_CORE_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb, fprod;
  logic        [XLEN-1:0]   fast_res;

  // 33x33 signed product; the upper 64-bit wrap is harmless since the true product fits
  always_comb begin
    fa       = $signed({{XLEN{sa}}, bus.rs1_val});
    fb       = $signed({{XLEN{sb}}, bus.rs2_val});
    fprod    = fa * fb;
    fast_res = (bus.funct3 == F3_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
  end
`endif

  // iteration datapath: shift-add multiply / restoring divide share acc_q
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc, div_acc;
  logic [XLEN-1:0]   div_rem;
  logic              div_qbit;

  z_core_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i   (acc_q[2*XLEN-1:XLEN]),
    .din     (acc_q[XLEN-1]),
    .divisor (op_q),
    .rem_o   (div_rem),
    .q_bit   (div_qbit)
  );

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_q[0]}} & {1'b0, op_q});
    mul_acc = {mul_sum, acc_q[XLEN-1:1]};
    div_acc = {div_rem, acc_q[XLEN-2:0], div_qbit};
  end

  // final result with sign correction
  logic [XLEN-1:0]   q_sel, done_res;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    q_sel = ctl_q.f3[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    prod  = ctl_q.neg ? -acc_q : acc_q;
    if (ctl_q.byp)                done_res = acc_q[XLEN-1:0];
    else if (ctl_q.f3[2])         done_res = cond_neg(q_sel, ctl_q.neg);
    else if (ctl_q.f3 == F3_MUL)  done_res = prod[XLEN-1:0];
    else                          done_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    op_d      = op_q;
    ctl_d     = ctl_q;
    rv_d      = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          ctl_d.f3  = bus.funct3;
          ctl_d.rd  = bus.rd_in_idx;
          ctl_d.neg = neg;
          ctl_d.byp = 1'b0;
          cnt_d     = '0;
          if (div0 || ovf) begin
            ctl_d.byp = 1'b1;
            acc_d     = {{XLEN{1'b0}}, spec_res};
            state_d   = ST_DONE;
          end else if (is_div) begin
            op_d    = abs_b;
            acc_d   = {{XLEN{1'b0}}, abs_a};
            state_d = ST_CALC;
          end else begin
`ifdef Z_CORE_FAST_MUL_EN
            ctl_d.byp = 1'b1;
            acc_d     = {{XLEN{1'b0}}, fast_res};
            state_d   = ST_DONE;
`else
            op_d    = abs_a;
            acc_d   = {{XLEN{1'b0}}, abs_b};
            state_d = ST_CALC;
`endif
          end
        end
      end
      ST_CALC: begin
        acc_d = ctl_q.f3[2] ? div_acc : mul_acc;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_DONE;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        rv_d      = 1'b1;
        wb_rd_d   = ctl_q.rd;
        wb_data_d = done_res;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) begin
      state_d   = ST_IDLE;
      rv_d      = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      op_q      <= '0;
      ctl_q     <= '0;
      rv_q      <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      ctl_q     <= ctl_d;
      rv_q      <= rv_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.ready        = (state_q == ST_IDLE);
  assign bus.busy         = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign bus.result_valid = rv_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_we        = rv_q && (wb_rd_q != 5'd0);

endmodule
